sdram_port_arb: RTL and testbench

Round-robin arbiter that shares one toggle-handshake SDRAM controller port (`port1_*` or `port2_*` of `sdram_1w`) among up to eight independent requesters. Each requester sees its own toggle req/ack port. The arbiter grants one request at a time, forwards address, write data and byte enables, and returns read data to the granted requester only. It sits between core-side clients (ROM loader, sprite DMA, debug) and `sdram_1w`, in the same clock domain.

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_arb_rr.sv | 41 ++++
 rtl/sdram_port_arb.sv | 160 ++++++++++++++++
 tb/tb_sdram_port_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM controller-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int unsigned AW_DEF   = 23;
    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned DW       = 16;

    localparam logic [DW-1:0] WDOG_FILL = 16'hFFFF;

    // Per-requester transaction fields other than the address.
    typedef struct packed {
        logic          we;
        logic [1:0]    ds;
        logic [DW-1:0] d;
    } rq_fields_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// Circular priority pick: first pending index strictly after last, wrapping.
module sdram_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   grant,
    output logic            any
);

    logic          hi_any;
    logic          lo_any;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan so the lowest index in each half is the one that sticks.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (IW'(i) > last) begin
                    hi_any = 1'b1;
                    hi_idx = IW'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = IW'(i);
                end
            end
        end
    end

    assign grant = hi_any ? hi_idx : lo_idx;
    assign any   = hi_any | lo_any;

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port among NREQ requesters.
// Optional watchdog on the controller handshake: define SDRAM_ARB_WDOG_EN.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned AW          = AW_DEF,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    rq_req,
    output logic [NREQ-1:0]    rq_ack,
    input  logic [NREQ-1:0]    rq_we,
    input  logic [NREQ*AW-1:0] rq_a,
    input  logic [NREQ*2-1:0]  rq_ds,
    input  logic [NREQ*16-1:0] rq_d,
    output logic [NREQ*16-1:0] rq_q,
    output logic               sd_req,
    input  logic               sd_ack,
    output logic               sd_we,
    output logic [AW-1:0]      sd_a,
    output logic [1:0]         sd_ds,
    output logic [15:0]        sd_d,
    input  logic [15:0]        sd_q,
    output logic               busy,
    output logic               wdog_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= NREQ_MAX) && (WDOG_CYCLES >= 1);

    if (!CFG_OK) begin : g_cfg_err
        $error("sdram_port_arb: NREQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    arb_state_t      state;
    arb_state_t      state_nx;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick;
    logic            any;
    logic            take;
    logic            ack_match;
    logic            wdog_hit;
    logic            finish;
    logic [NREQ-1:0] pending;
    logic [AW-1:0]   sel_a;
    rq_fields_t      sel;

    assign pending   = rq_req ^ rq_ack;
    assign ack_match = (sd_ack == sd_req);
    assign finish    = (state == WAIT) && (ack_match || wdog_hit);

    sdram_arb_rr #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .pending (pending),
        .last    (last),
        .grant   (pick),
        .any     (any)
    );

    // Fields of the requester the picker currently favours.
    always_comb begin
        sel_a = '0;
        sel   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick == IW'(i)) begin
                sel_a  = rq_a[i*AW +: AW];
                sel.we = rq_we[i];
                sel.ds = rq_ds[i*2 +: 2];
                sel.d  = rq_d[i*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nx = WAIT;
                    take     = 1'b1;
                end
            end
            WAIT:    if (ack_match || wdog_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef SDRAM_ARB_WDOG_EN
    localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

    logic [CW-1:0] wdog_cnt;

    // Counts WAIT cycles; held at zero outside WAIT so each transaction starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              wdog_cnt <= '0;
        else if (state == WAIT) wdog_cnt <= wdog_cnt + CW'(1);
        else                    wdog_cnt <= '0;
    end

    assign wdog_hit = (state == WAIT) && !ack_match && (wdog_cnt == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         wdog_err <= 1'b0;
        else if (wdog_hit) wdog_err <= 1'b1;
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant  <= '0;
            last   <= IW'(NREQ - 1);
            sd_req <= 1'b0;
            sd_we  <= 1'b0;
            sd_a   <= '0;
            sd_ds  <= '0;
            sd_d   <= '0;
            rq_ack <= '0;
            rq_q   <= '0;
            busy   <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            if (take) begin
                grant  <= pick;
                sd_req <= ~sd_req;
                sd_we  <= sel.we;
                sd_a   <= sel_a;
                sd_ds  <= sel.ds;
                sd_d   <= sel.we ? sel.d : 16'h0000;
            end
            // Read data lands on the edge the handshake completes; a timeout fills instead.
            if (finish && !sd_we) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (grant == IW'(i)) rq_q[i*16 +: 16] <= ack_match ? sd_q : WDOG_FILL;
                end
            end
            if (state == DONE) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (grant == IW'(i)) rq_ack[i] <= ~rq_ack[i];
                end
                last <= grant;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb with a delayed-ack controller model.
module tb_sdram_port_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 23;
    localparam int unsigned WDOG = 16;

    logic               clk    = 1'b0;
    logic               reset  = 1'b1;
    logic [NREQ-1:0]    rq_req = '0;
    logic [NREQ-1:0]    rq_ack;
    logic [NREQ-1:0]    rq_we  = '0;
    logic [NREQ*AW-1:0] rq_a   = '0;
    logic [NREQ*2-1:0]  rq_ds  = '0;
    logic [NREQ*16-1:0] rq_d   = '0;
    logic [NREQ*16-1:0] rq_q;
    logic               sd_req;
    logic               sd_ack;
    logic               sd_we;
    logic [AW-1:0]      sd_a;
    logic [1:0]         sd_ds;
    logic [15:0]        sd_d;
    logic [15:0]        sd_q;
    logic               busy;
    logic               wdog_err;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int ctl_delay = 2;
    int ctl_cnt   = 0;
    bit ctl_noack = 1'b0;
    logic [15:0] mem [int unsigned];

    sdram_port_arb #(.NREQ(NREQ), .AW(AW), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset),
        .rq_req(rq_req), .rq_ack(rq_ack), .rq_we(rq_we), .rq_a(rq_a),
        .rq_ds(rq_ds), .rq_d(rq_d), .rq_q(rq_q),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_we(sd_we), .sd_a(sd_a),
        .sd_ds(sd_ds), .sd_d(sd_d), .sd_q(sd_q),
        .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dflt(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {a[22:16], 9'h000};
    endfunction

    function automatic logic [15:0] rd_val(input logic [AW-1:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return dflt(a);
    endfunction

    // Controller model: acks ctl_delay cycles after it first sees a new request.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_ack  <= 1'b0;
            sd_q    <= '0;
            ctl_cnt <= 0;
        end else if (sd_req != sd_ack && !ctl_noack) begin
            if (ctl_cnt >= ctl_delay - 1) begin
                sd_ack  <= sd_req;
                ctl_cnt <= 0;
                if (!sd_we) sd_q <= rd_val(sd_a);
            end else begin
                ctl_cnt <= ctl_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [1:0] ds, input logic [15:0] d);
        rq_we[i]            = we;
        rq_a[i*AW +: AW]    = a;
        rq_ds[i*2 +: 2]     = ds;
        rq_d[i*16 +: 16]    = d;
        rq_req[i]           = ~rq_req[i];
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rq_req    = '0;
        rq_we     = '0;
        rq_a      = '0;
        rq_ds     = '0;
        rq_d      = '0;
        ctl_noack = 1'b0;
        ctl_delay = 2;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_sd_toggle(input int budget, output bit ok);
        logic p;
        p  = sd_req;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (sd_req !== p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int i, input int budget, output bit ok);
        logic p;
        p  = rq_ack[i];
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (rq_ack[i] !== p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rq_ack !== '0) begin n_fail++; $display("FAIL reset_rq_ack: got %h expected 0", rq_ack); end
        n_checks++; if (rq_q !== '0) begin n_fail++; $display("FAIL reset_rq_q: got %h expected 0", rq_q); end
        n_checks++; if (sd_req !== 1'b0) begin n_fail++; $display("FAIL reset_sd_req: got %b expected 0", sd_req); end
        n_checks++; if ({sd_we, sd_ds, sd_d} !== '0) begin n_fail++; $display("FAIL reset_sd_cmd: got %b/%b/%h expected 0", sd_we, sd_ds, sd_d); end
        n_checks++; if (sd_a !== '0) begin n_fail++; $display("FAIL reset_sd_a: got %h expected 0", sd_a); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL reset_wdog_err: got %b expected 0", wdog_err); end
    endtask

    task automatic test_single_read();
        bit ok;
        int s;
        int extra;
        logic p;
        do_reset();
        mem[32'h12345] = 16'hBEEF;
        ctl_delay = 8;
        issue(2, 1'b0, 23'h12345, 2'b11, 16'h1111);
        tick();
        s = cyc;
        n_checks++; if (sd_req !== 1'b1) begin n_fail++; $display("FAIL rd_sd_req_latency: got %b expected 1", sd_req); end
        n_checks++; if (sd_a !== 23'h12345) begin n_fail++; $display("FAIL rd_sd_a: got %h expected 12345", sd_a); end
        n_checks++; if (sd_we !== 1'b0 || sd_d !== 16'h0000) begin n_fail++; $display("FAIL rd_sd_we_d: got %b/%h expected 0/0000", sd_we, sd_d); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b expected 1", busy); end
        wait_ack(2, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_ack_timeout: got no ack expected ack"); end
        n_checks++; if (cyc - s != 10) begin n_fail++; $display("FAIL rd_ack_latency: got %0d expected 10", cyc - s); end
        n_checks++; if (rq_q[2*16 +: 16] !== 16'hBEEF) begin n_fail++; $display("FAIL rd_q: got %h expected beef", rq_q[2*16 +: 16]); end
        extra = 0;
        p = rq_ack[2];
        repeat (20) begin
            tick();
            if (rq_ack[2] !== p) extra++;
            p = rq_ack[2];
        end
        n_checks++; if (extra != 0 || rq_ack !== 4'b0100) begin n_fail++; $display("FAIL rd_ack_once: got %b extra=%0d expected 0100 extra=0", rq_ack, extra); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int got;
        logic [AW-1:0] a;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                a = {3'(i), 20'(r * 256 + i)};
                issue(i, 1'b0, a, 2'b11, 16'h0000);
            end
            for (int k = 0; k < int'(NREQ); k++) begin
                wait_sd_toggle(20, ok);
                got = ok ? int'(sd_a[AW-1 -: 3]) : -1;
                n_checks++; if (got != k) begin n_fail++; $display("FAIL rr_order round %0d slot %0d: got %0d expected %0d", r, k, got, k); end
            end
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (rq_ack === rq_req) begin ok = 1'b1; break; end
            end
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_all_acked round %0d: got %b expected %b", r, rq_ack, rq_req); end
        end
    endtask

    task automatic test_write();
        bit ok;
        do_reset();
        issue(1, 1'b0, 23'h02222, 2'b11, 16'h0000);
        wait_ack(1, 30, ok);
        issue(1, 1'b1, 23'h03000, 2'b01, 16'h00A5);
        wait_sd_toggle(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_grant_timeout: got no grant expected grant"); end
        n_checks++; if ({sd_we, sd_ds, sd_d} !== {1'b1, 2'b01, 16'h00A5}) begin n_fail++; $display("FAIL wr_cmd: got %b/%b/%h expected 1/01/00a5", sd_we, sd_ds, sd_d); end
        n_checks++; if (sd_a !== 23'h03000) begin n_fail++; $display("FAIL wr_sd_a: got %h expected 3000", sd_a); end
        wait_ack(1, 30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_ack_timeout: got no ack expected ack"); end
        n_checks++; if (rq_q[16 +: 16] !== dflt(23'h02222)) begin n_fail++; $display("FAIL wr_q_unchanged: got %h expected %h", rq_q[16 +: 16], dflt(23'h02222)); end
    endtask

    task automatic test_sample_hold();
        bit ok;
        bit held;
        do_reset();
        ctl_delay = 6;
        issue(0, 1'b0, 23'h00777, 2'b11, 16'h0000);
        tick();
        n_checks++; if (sd_req !== 1'b1) begin n_fail++; $display("FAIL hold_grant: got %b expected 1", sd_req); end
        tick();
        rq_a[0 +: AW] = 23'h05555;
        held = 1'b1;
        ok   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sd_a !== 23'h00777) held = 1'b0;
            if (rq_ack[0] === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || !held) begin n_fail++; $display("FAIL hold_sd_a: got ack=%b held=%b sd_a=%h expected ack=1 held=1 sd_a=777", ok, held, sd_a); end
        n_checks++; if (rq_q[15:0] !== dflt(23'h00777)) begin n_fail++; $display("FAIL hold_q: got %h expected %h", rq_q[15:0], dflt(23'h00777)); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        bit quiet;
        do_reset();
        issue(1, 1'b0, 23'h00444, 2'b11, 16'h0000);
        wait_ack(1, 30, ok);
        issue(2, 1'b0, 23'h00555, 2'b11, 16'h0000);
        wait_ack(2, 30, ok);
        ctl_noack = 1'b1;
        issue(3, 1'b0, 23'h00666, 2'b11, 16'h0000);
        wait_sd_toggle(20, ok);
        n_checks++; if (!ok || sd_req !== 1'b1) begin n_fail++; $display("FAIL rstw_grant: got ok=%b sd_req=%b expected 1/1", ok, sd_req); end
        repeat (3) tick();
        @(negedge clk);
        reset  = 1'b1;
        rq_req = '0;
        #1;
        n_checks++; if (sd_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_async_ctrl: got sd_req=%b busy=%b expected 0/0", sd_req, busy); end
        n_checks++; if (rq_ack !== '0 || rq_q !== '0) begin n_fail++; $display("FAIL rstw_async_rq: got ack=%b q=%h expected 0", rq_ack, rq_q); end
        n_checks++; if ({sd_we, sd_ds, sd_d, sd_a} !== '0) begin n_fail++; $display("FAIL rstw_async_cmd: got %b/%b/%h/%h expected 0", sd_we, sd_ds, sd_d, sd_a); end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ctl_noack = 1'b0;
        quiet     = 1'b1;
        repeat (30) begin
            tick();
            if (rq_ack !== '0 || sd_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (!quiet) begin n_fail++; $display("FAIL rstw_no_ack: got ack=%b sd_req=%b expected 0/0", rq_ack, sd_req); end
    endtask

`ifdef SDRAM_ARB_WDOG_EN
    task automatic test_wdog();
        bit ok;
        int e;
        do_reset();
        ctl_noack = 1'b1;
        issue(0, 1'b0, 23'h00055, 2'b11, 16'h0000);
        tick();
        e = cyc;
        n_checks++; if (sd_req !== 1'b1) begin n_fail++; $display("FAIL wdog_grant: got %b expected 1", sd_req); end
        wait_ack(0, 40, ok);
        n_checks++; if (!ok || cyc - e != 17) begin n_fail++; $display("FAIL wdog_latency: got ok=%b dt=%0d expected 1/17", ok, cyc - e); end
        n_checks++; if (rq_q[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL wdog_fill: got %h expected ffff", rq_q[15:0]); end
        n_checks++; if (wdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_err_set: got %b expected 1", wdog_err); end
        repeat (10) tick();
        n_checks++; if (wdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_err_sticky: got %b expected 1", wdog_err); end
        do_reset();
        n_checks++; if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_err_clear: got %b expected 0", wdog_err); end
    endtask
`endif

    task automatic test_random();
        int              ntx;
        bit              outst [NREQ];
        logic            t_we  [NREQ];
        logic [AW-1:0]   t_a   [NREQ];
        logic [1:0]      t_ds  [NREQ];
        logic [15:0]     t_d   [NREQ];
        logic [15:0]     exp_q [NREQ];
        int              waited[NREQ];
        logic [NREQ-1:0] snap;
        logic [NREQ-1:0] prev_ack;
        logic            prev_req;
        logic [NREQ*16-1:0] exp_vec;
        int ref_last, issued, done, cur, exp_g, got_g, idx;
        ntx = 80;
        do_reset();
        mem.delete();
        for (int i = 0; i < int'(NREQ); i++) begin
            outst[i] = 1'b0; t_we[i] = 1'b0; t_a[i] = '0; t_ds[i] = '0; t_d[i] = '0;
            exp_q[i] = '0; waited[i] = 0;
        end
        ref_last = int'(NREQ) - 1;
        issued = 0; done = 0; cur = -1;
        prev_req = sd_req;
        prev_ack = rq_ack;
        for (int c = 0; c < 4000 && done < ntx; c++) begin
            @(posedge clk);
            for (int i = 0; i < int'(NREQ); i++) snap[i] = outst[i];
            #1;
            if (sd_req !== prev_req) begin
                exp_g = -1;
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (ref_last + k) % int'(NREQ);
                    if (exp_g < 0 && snap[idx]) exp_g = idx;
                end
                got_g = int'(sd_a[AW-1 -: 3]);
                n_checks++; if (got_g != exp_g) begin n_fail++; $display("FAIL rand_grant: got %0d expected %0d (pending %b)", got_g, exp_g, snap); end
                if (exp_g >= 0) begin
                    n_checks++;
                    if ({sd_we, sd_ds, sd_d, sd_a} !== {t_we[exp_g], t_ds[exp_g], t_we[exp_g] ? t_d[exp_g] : 16'h0000, t_a[exp_g]}) begin
                        n_fail++;
                        $display("FAIL rand_fields: got %b/%b/%h/%h expected %b/%b/%h/%h", sd_we, sd_ds, sd_d, sd_a,
                                 t_we[exp_g], t_ds[exp_g], t_we[exp_g] ? t_d[exp_g] : 16'h0000, t_a[exp_g]);
                    end
                    n_checks++; if (waited[exp_g] > int'(NREQ) - 1) begin n_fail++; $display("FAIL rand_fairness: got %0d waits expected <= %0d", waited[exp_g], NREQ - 1); end
                    for (int j = 0; j < int'(NREQ); j++) if (j != exp_g && snap[j]) waited[j]++;
                    waited[exp_g] = 0;
                    ref_last = exp_g;
                    cur = exp_g;
                end
                ctl_delay = int'($urandom_range(1, 6));
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (rq_ack[i] !== prev_ack[i]) begin
                    n_checks++; if (i != cur || !outst[i]) begin n_fail++; $display("FAIL rand_ack_owner: got %0d expected %0d", i, cur); end
                    if (!t_we[i]) exp_q[i] = dflt(t_a[i]);
                    for (int j = 0; j < int'(NREQ); j++) exp_vec[j*16 +: 16] = exp_q[j];
                    n_checks++; if (rq_q !== exp_vec) begin n_fail++; $display("FAIL rand_q: got %h expected %h", rq_q, exp_vec); end
                    outst[i] = 1'b0;
                    done++;
                    cur = -1;
                end
            end
            prev_req = sd_req;
            prev_ack = rq_ack;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!outst[i] && issued < ntx && $urandom_range(0, 2) == 0) begin
                    t_we[i] = 1'($urandom_range(0, 1));
                    t_a[i]  = {3'(i), t_we[i], 19'($urandom)};
                    t_ds[i] = 2'($urandom_range(1, 3));
                    t_d[i]  = 16'($urandom);
                    issue(i, t_we[i], t_a[i], t_ds[i], t_d[i]);
                    outst[i] = 1'b1;
                    issued++;
                end
            end
        end
        n_checks++; if (done != ntx) begin n_fail++; $display("FAIL rand_timeout: got %0d completions expected %0d", done, ntx); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_sample_hold();
        test_reset_in_wait();
`ifdef SDRAM_ARB_WDOG_EN
        test_wdog();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
